// File: rtl/exc_ctrl.sv
// exc_ctrl: exception arbiter and pipeline redirect unit.
// Samples MEM-stage exception flags plus forwarded CP0 Status/Cause/EPC,
// selects the highest-priority event, reports it to CP0 for one cycle,
// flushes the pipeline with a redirect PC, then ignores MEM-stage inputs
// for BLANK_CYCLES cycles while the pipeline refills.
// Optional feature macro: EXC_BEV_EN (vector chosen by Status.BEV).
// Ports:
//   clk, rst                 clock, async active-high reset
//   mem_valid_i, stall_i     MEM-stage qualifiers
//   pc_i, is_in_delayslot_i  instruction PC and delay-slot flag
//   mem_addr_i               load/store data address
//   exc_*_i, eret_i          per-instruction exception flags
//   status_i/cause_i/epc_i   forwarded CP0 registers
//   exception_occured_o      one-cycle report to CP0
//   exc_code_o, epc_pc_o, is_in_delayslot_o, bad_addr_o  report payload
//   flush_o, new_pc_o        pipeline flush and redirect target
module exc_ctrl #(
  parameter logic [31:0] EXC_VECTOR   = 32'hBFC00380,
  parameter int unsigned BLANK_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_valid_i,
  input  logic        stall_i,
  input  logic [31:0] pc_i,
  input  logic        is_in_delayslot_i,
  input  logic [31:0] mem_addr_i,
  input  logic        exc_adel_if_i,
  input  logic        exc_ri_i,
  input  logic        exc_sys_i,
  input  logic        exc_bp_i,
  input  logic        exc_ov_i,
  input  logic        exc_adel_ld_i,
  input  logic        exc_ades_i,
  input  logic        eret_i,
  input  logic [31:0] status_i,
  input  logic [31:0] cause_i,
  input  logic [31:0] epc_i,
  output logic        exception_occured_o,
  output logic [4:0]  exc_code_o,
  output logic [31:0] epc_pc_o,
  output logic        is_in_delayslot_o,
  output logic [31:0] bad_addr_o,
  output logic        flush_o,
  output logic [31:0] new_pc_o
);

  localparam int unsigned CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FLUSH = 2'd1,
    BLANK = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] blank_cnt, blank_cnt_nxt;

  logic        int_pending, any_exc, take;
  logic [4:0]  sel_code;
  logic [31:0] sel_bad;
  logic        sel_eret;
  logic [31:0] vec_pc;

  logic        exc_occ_nxt, flush_nxt, ds_nxt;
  logic [4:0]  code_nxt;
  logic [31:0] epc_pc_nxt, bad_nxt, new_pc_nxt;

  // Interrupt: unmasked pending line, IE set, not already at exception level
  assign int_pending = (|(status_i[15:8] & cause_i[15:8])) & status_i[0] & ~status_i[1];
  assign any_exc     = exc_adel_if_i | exc_ri_i | exc_sys_i | exc_bp_i |
                       exc_ov_i | exc_adel_ld_i | exc_ades_i;
  assign take        = (state == IDLE) & mem_valid_i & ~stall_i &
                       (int_pending | any_exc | eret_i);

  // Fixed-priority event select; ERET only when nothing else is raised
  always_comb begin
    sel_code = 5'h10;
    sel_bad  = 32'h0;
    sel_eret = 1'b0;
    if (int_pending) begin
      sel_code = 5'h00;
    end else if (exc_adel_if_i) begin
      sel_code = 5'h04;
      sel_bad  = pc_i;
    end else if (exc_ri_i) begin
      sel_code = 5'h0a;
    end else if (exc_sys_i) begin
      sel_code = 5'h08;
    end else if (exc_bp_i) begin
      sel_code = 5'h09;
    end else if (exc_ov_i) begin
      sel_code = 5'h0c;
    end else if (exc_adel_ld_i) begin
      sel_code = 5'h04;
      sel_bad  = mem_addr_i;
    end else if (exc_ades_i) begin
      sel_code = 5'h05;
      sel_bad  = mem_addr_i;
    end else begin
      sel_eret = 1'b1;
    end
  end

`ifdef EXC_BEV_EN
  // Boot-time vs normal exception vector selected by Status.BEV
  assign vec_pc = status_i[22] ? 32'hBFC00380 : 32'h80000180;
  logic unused_bits;
  assign unused_bits = ^{status_i[31:23], status_i[21:16], status_i[7:2],
                         cause_i[31:16], cause_i[7:0], EXC_VECTOR};
`else
  assign vec_pc = EXC_VECTOR;
  logic unused_bits;
  assign unused_bits = ^{status_i[31:16], status_i[7:2],
                         cause_i[31:16], cause_i[7:0]};
`endif

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      blank_cnt <= '0;
    end else begin
      state     <= state_nxt;
      blank_cnt <= blank_cnt_nxt;
    end
  end

  // Next-state logic; BLANK lasts BLANK_CYCLES cycles
  always_comb begin
    state_nxt     = state;
    blank_cnt_nxt = blank_cnt;
    unique case (state)
      IDLE: begin
        if (take) state_nxt = FLUSH;
      end
      FLUSH: begin
        if (BLANK_CYCLES == 0) begin
          state_nxt = IDLE;
        end else begin
          state_nxt     = BLANK;
          blank_cnt_nxt = CNT_W'(BLANK_CYCLES);
        end
      end
      BLANK: begin
        if (blank_cnt <= CNT_W'(1)) begin
          state_nxt     = IDLE;
          blank_cnt_nxt = '0;
        end else begin
          blank_cnt_nxt = blank_cnt - CNT_W'(1);
        end
      end
      default: begin
        state_nxt     = IDLE;
        blank_cnt_nxt = '0;
      end
    endcase
  end

  // Output next values: pulses only on take, payload held otherwise
  always_comb begin
    exc_occ_nxt = 1'b0;
    flush_nxt   = 1'b0;
    code_nxt    = exc_code_o;
    epc_pc_nxt  = epc_pc_o;
    ds_nxt      = is_in_delayslot_o;
    bad_nxt     = bad_addr_o;
    new_pc_nxt  = new_pc_o;
    if (take) begin
      exc_occ_nxt = 1'b1;
      flush_nxt   = 1'b1;
      code_nxt    = sel_code;
      epc_pc_nxt  = pc_i;
      ds_nxt      = is_in_delayslot_i;
      bad_nxt     = sel_bad;
      new_pc_nxt  = sel_eret ? epc_i : vec_pc;
    end
  end

  // Output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      exception_occured_o <= 1'b0;
      flush_o             <= 1'b0;
      exc_code_o          <= 5'h0;
      epc_pc_o            <= 32'h0;
      is_in_delayslot_o   <= 1'b0;
      bad_addr_o          <= 32'h0;
      new_pc_o            <= 32'h0;
    end else begin
      exception_occured_o <= exc_occ_nxt;
      flush_o             <= flush_nxt;
      exc_code_o          <= code_nxt;
      epc_pc_o            <= epc_pc_nxt;
      is_in_delayslot_o   <= ds_nxt;
      bad_addr_o          <= bad_nxt;
      new_pc_o            <= new_pc_nxt;
    end
  end

endmodule

// File: tb/tb_exc_ctrl.sv
// Testbench for exc_ctrl: directed vector table, hand-written multi-cycle
// sequences, and randomized stimulus against a behavioural model.
module tb_exc_ctrl;

  localparam int unsigned BLANK = 2;
  localparam logic [31:0] VEC   = 32'hBFC00380;

  logic        clk, rst;
  logic        mem_valid_i, stall_i, is_in_delayslot_i;
  logic [31:0] pc_i, mem_addr_i, status_i, cause_i, epc_i;
  logic        exc_adel_if_i, exc_ri_i, exc_sys_i, exc_bp_i, exc_ov_i;
  logic        exc_adel_ld_i, exc_ades_i, eret_i;
  logic        exception_occured_o, is_in_delayslot_o, flush_o;
  logic [4:0]  exc_code_o;
  logic [31:0] epc_pc_o, bad_addr_o, new_pc_o;

  exc_ctrl #(.EXC_VECTOR(VEC), .BLANK_CYCLES(BLANK)) dut (
    .clk(clk), .rst(rst),
    .mem_valid_i(mem_valid_i), .stall_i(stall_i), .pc_i(pc_i),
    .is_in_delayslot_i(is_in_delayslot_i), .mem_addr_i(mem_addr_i),
    .exc_adel_if_i(exc_adel_if_i), .exc_ri_i(exc_ri_i), .exc_sys_i(exc_sys_i),
    .exc_bp_i(exc_bp_i), .exc_ov_i(exc_ov_i), .exc_adel_ld_i(exc_adel_ld_i),
    .exc_ades_i(exc_ades_i), .eret_i(eret_i),
    .status_i(status_i), .cause_i(cause_i), .epc_i(epc_i),
    .exception_occured_o(exception_occured_o), .exc_code_o(exc_code_o),
    .epc_pc_o(epc_pc_o), .is_in_delayslot_o(is_in_delayslot_o),
    .bad_addr_o(bad_addr_o), .flush_o(flush_o), .new_pc_o(new_pc_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        valid;
    logic        stall;
    logic [31:0] pc;
    logic        ds;
    logic [31:0] addr;
    logic        adel_if, ri, sys, bp, ov, adel_ld, ades, eret;
    logic [31:0] status, cause, epc;
  } in_t;

  typedef struct {
    in_t         in;
    logic        take;
    logic [4:0]  code;
    logic [31:0] epc_pc;
    logic        ds;
    logic [31:0] bad;
    logic [31:0] npc;
  } vec_t;

  int checks   = 0;
  int failures = 0;

  vec_t vecs[12];
  in_t  cur;

  // Model state: number of upcoming edges at which inputs are ignored
  int          m_ign;
  logic        m_occ, m_ds;
  logic [4:0]  m_code;
  logic [31:0] m_epc, m_bad, m_npc;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input in_t x);
    cur               = x;
    mem_valid_i       = x.valid;
    stall_i           = x.stall;
    pc_i              = x.pc;
    is_in_delayslot_i = x.ds;
    mem_addr_i        = x.addr;
    exc_adel_if_i     = x.adel_if;
    exc_ri_i          = x.ri;
    exc_sys_i         = x.sys;
    exc_bp_i          = x.bp;
    exc_ov_i          = x.ov;
    exc_adel_ld_i     = x.adel_ld;
    exc_ades_i        = x.ades;
    eret_i            = x.eret;
    status_i          = x.status;
    cause_i           = x.cause;
    epc_i             = x.epc;
  endtask

  function automatic logic [31:0] vector_for(input logic [31:0] st);
`ifdef EXC_BEV_EN
    return st[22] ? 32'hBFC00380 : 32'h80000180;
`else
    return (st[22] === 1'bx) ? VEC : VEC;
`endif
  endfunction

  // Behavioural reference: walk the priority list, first raised event wins
  task automatic model_edge(input in_t x);
    logic [8:0] ev;
    logic [4:0] codes [9];
    logic       irq;
    int         w;
    codes = '{5'h00, 5'h04, 5'h0a, 5'h08, 5'h09, 5'h0c, 5'h04, 5'h05, 5'h10};
    irq   = (|(x.status[15:8] & x.cause[15:8])) && x.status[0] && !x.status[1];
    ev    = {x.eret, x.ades, x.adel_ld, x.ov, x.bp, x.sys, x.ri, x.adel_if, irq};
    m_occ = 1'b0;
    if (m_ign > 0) begin
      m_ign--;
    end else if (x.valid && !x.stall && ev != 9'h0) begin
      w = 0;
      for (int i = 8; i >= 0; i--) if (ev[i]) w = i;
      m_occ  = 1'b1;
      m_code = codes[w];
      m_epc  = x.pc;
      m_ds   = x.ds;
      m_bad  = (w == 1) ? x.pc : ((w == 6 || w == 7) ? x.addr : 32'h0);
      m_npc  = (w == 8) ? x.epc : vector_for(x.status);
      m_ign  = 1 + BLANK;
    end
  endtask

  task automatic compare_model(input string tag);
    check({tag, " occ"},   32'(exception_occured_o), 32'(m_occ));
    check({tag, " flush"}, 32'(flush_o),             32'(m_occ));
    check({tag, " code"},  32'(exc_code_o),          32'(m_code));
    check({tag, " epc"},   epc_pc_o,                 m_epc);
    check({tag, " ds"},    32'(is_in_delayslot_o),   32'(m_ds));
    check({tag, " bad"},   bad_addr_o,               m_bad);
    check({tag, " npc"},   new_pc_o,                 m_npc);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_gap;
    in_t z;
    z = '0;
    drive(z);
    for (int i = 0; i < int'(BLANK) + 1; i++) tick();
  endtask

  task automatic set_vec(input int idx, input in_t x, input logic tk, input logic [4:0] code,
                         input logic [31:0] epc, input logic ds, input logic [31:0] bad,
                         input logic [31:0] npc);
    vecs[idx].in     = x;
    vecs[idx].take   = tk;
    vecs[idx].code   = code;
    vecs[idx].epc_pc = epc;
    vecs[idx].ds     = ds;
    vecs[idx].bad    = bad;
    vecs[idx].npc    = npc;
  endtask

  task automatic do_reset;
    in_t z;
    z = '0;
    drive(z);
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    m_ign = 0; m_occ = 0; m_ds = 0; m_code = '0; m_epc = '0; m_bad = '0; m_npc = '0;
  endtask

  initial begin
    in_t b, r;
    logic [31:0] exp_npc;
    rst = 1'b1;
    b = '0;
    drive(b);

    // Directed vector table
    b = '0; b.valid = 1; b.pc = 32'h8000_1000; b.sys = 1;
    set_vec(0, b, 1, 5'h08, 32'h8000_1000, 0, 32'h0, VEC);
    b = '0; b.valid = 1; b.pc = 32'h8000_1004; b.ades = 1; b.addr = 32'h3; b.ds = 1;
    set_vec(1, b, 1, 5'h05, 32'h8000_1004, 1, 32'h3, VEC);
    b = '0; b.valid = 1; b.pc = 32'h8000_2000; b.ov = 1; b.status = 32'h401; b.cause = 32'h400;
    set_vec(2, b, 1, 5'h00, 32'h8000_2000, 0, 32'h0, VEC);
    b.status = 32'h403;
    set_vec(3, b, 1, 5'h0c, 32'h8000_2000, 0, 32'h0, VEC);
    b = '0; b.valid = 1; b.pc = 32'h8000_3000; b.eret = 1; b.epc = 32'hBFC0_0100;
    set_vec(4, b, 1, 5'h10, 32'h8000_3000, 0, 32'h0, 32'hBFC0_0100);
    b = '0; b.valid = 1; b.pc = 32'h8000_2001; b.adel_if = 1; b.ri = 1;
    set_vec(5, b, 1, 5'h04, 32'h8000_2001, 0, 32'h8000_2001, VEC);
    b = '0; b.valid = 1; b.pc = 32'h8000_4000; b.ri = 1; b.sys = 1; b.eret = 1; b.epc = 32'h1234;
    set_vec(6, b, 1, 5'h0a, 32'h8000_4000, 0, 32'h0, VEC);
    b = '0; b.valid = 1; b.pc = 32'h8000_5000; b.adel_ld = 1; b.addr = 32'h8000_0011; b.eret = 1;
    set_vec(7, b, 1, 5'h04, 32'h8000_5000, 0, 32'h8000_0011, VEC);
    b = '0; b.valid = 1; b.pc = 32'h8000_6000; b.bp = 1; b.ov = 1; b.ds = 1;
    set_vec(8, b, 1, 5'h09, 32'h8000_6000, 1, 32'h0, VEC);
    b = '0; b.valid = 1; b.stall = 1; b.pc = 32'h8000_7000; b.sys = 1;
    set_vec(9, b, 0, 5'h0, 32'h0, 0, 32'h0, 32'h0);
    b = '0; b.valid = 0; b.status = 32'h401; b.cause = 32'h400;
    set_vec(10, b, 0, 5'h0, 32'h0, 0, 32'h0, 32'h0);
    b = '0; b.valid = 1; b.status = 32'h400; b.cause = 32'h400;
    set_vec(11, b, 0, 5'h0, 32'h0, 0, 32'h0, 32'h0);

    do_reset();
    check("reset occ",   32'(exception_occured_o), 32'h0);
    check("reset flush", 32'(flush_o),             32'h0);
    check("reset epc",   epc_pc_o,                 32'h0);
    check("reset npc",   new_pc_o,                 32'h0);

    foreach (vecs[i]) begin
      drive(vecs[i].in);
      tick();
      check($sformatf("vec%0d occ", i),   32'(exception_occured_o), 32'(vecs[i].take));
      check($sformatf("vec%0d flush", i), 32'(flush_o),             32'(vecs[i].take));
      if (vecs[i].take) begin
        exp_npc = vecs[i].npc;
`ifdef EXC_BEV_EN
        if (vecs[i].code != 5'h10)
          exp_npc = vecs[i].in.status[22] ? 32'hBFC00380 : 32'h80000180;
`endif
        check($sformatf("vec%0d code", i), 32'(exc_code_o),        32'(vecs[i].code));
        check($sformatf("vec%0d epc", i),  epc_pc_o,               vecs[i].epc_pc);
        check($sformatf("vec%0d ds", i),   32'(is_in_delayslot_o), 32'(vecs[i].ds));
        check($sformatf("vec%0d bad", i),  bad_addr_o,             vecs[i].bad);
        check($sformatf("vec%0d npc", i),  new_pc_o,               exp_npc);
      end
      idle_gap();
      check($sformatf("vec%0d pulse end", i), 32'(exception_occured_o), 32'h0);
    end

    // Back-to-back: second event blanked for FLUSH + BLANK cycles
    b = '0; b.valid = 1; b.pc = 32'h8000_1000; b.sys = 1;
    drive(b);
    tick();
    check("b2b first", 32'(exc_code_o), 32'h08);
    b = '0; b.valid = 1; b.pc = 32'h8000_1100; b.bp = 1;
    drive(b);
    for (int i = 0; i < int'(BLANK) + 1; i++) begin
      tick();
      check($sformatf("b2b blank%0d", i), 32'(flush_o), 32'h0);
    end
    tick();
    check("b2b second occ",  32'(exception_occured_o), 32'h1);
    check("b2b second code", 32'(exc_code_o),          32'h09);
    check("b2b second epc",  epc_pc_o,                 32'h8000_1100);
    idle_gap();

    // Stall held three cycles on an RI
    b = '0; b.valid = 1; b.stall = 1; b.pc = 32'h8000_8000; b.ri = 1;
    drive(b);
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("stall%0d", i), 32'(exception_occured_o), 32'h0);
    end
    b.stall = 0;
    drive(b);
    tick();
    check("stall release occ",  32'(exception_occured_o), 32'h1);
    check("stall release code", 32'(exc_code_o),          32'h0a);
    idle_gap();

    // Reset during BLANK
    b = '0; b.valid = 1; b.pc = 32'h8000_9000; b.sys = 1; b.ds = 1;
    drive(b);
    tick();
    b = '0;
    drive(b);
    tick();
    #2 rst = 1'b1;
    #1;
    check("rst blank epc",  epc_pc_o,               32'h0);
    check("rst blank npc",  new_pc_o,               32'h0);
    check("rst blank ds",   32'(is_in_delayslot_o), 32'h0);
    check("rst blank code", 32'(exc_code_o),        32'h0);
    tick();
    rst = 1'b0;
    b = '0; b.valid = 1; b.pc = 32'h8000_A000; b.sys = 1;
    drive(b);
    tick();
    check("post rst occ", 32'(exception_occured_o), 32'h1);
    check("post rst epc", epc_pc_o,                 32'h8000_A000);

    // Randomized stimulus against the reference model
    do_reset();
    for (int n = 0; n < 400; n++) begin
      r = '0;
      r.valid   = ($urandom_range(0, 9) < 8);
      r.stall   = ($urandom_range(0, 4) == 0);
      r.pc      = $urandom;
      r.ds      = 1'($urandom_range(0, 1));
      r.addr    = $urandom;
      r.adel_if = ($urandom_range(0, 11) == 0);
      r.ri      = ($urandom_range(0, 11) == 0);
      r.sys     = ($urandom_range(0, 11) == 0);
      r.bp      = ($urandom_range(0, 11) == 0);
      r.ov      = ($urandom_range(0, 11) == 0);
      r.adel_ld = ($urandom_range(0, 11) == 0);
      r.ades    = ($urandom_range(0, 11) == 0);
      r.eret    = ($urandom_range(0, 5) == 0);
      r.status  = $urandom;
      r.status[1] = ($urandom_range(0, 3) == 0);
      r.cause   = $urandom & 32'h0000_FF00;
      if ($urandom_range(0, 1) == 0) r.cause = 32'h0;
      r.epc     = $urandom;
      drive(r);
      @(posedge clk);
      model_edge(cur);
      #1;
      compare_model($sformatf("rnd%0d", n));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/exc_ctrl.md
Name: exc_ctrl

Overview:
Exception arbiter and pipeline redirect unit; the producing end of the CP0 exception interface. Sits after the MEM stage and samples per-instruction exception flags plus the forwarded CP0 Status/Cause/EPC. Selects the highest-priority event and drives a one-cycle exception report into CP0. Issues the pipeline flush and the redirect PC, then blanks further detection while the pipeline refills.

Parameters:
EXC_VECTOR, 32'hBFC00380, general exception entry address.
BLANK_CYCLES, 2, cycles after a flush during which MEM-stage inputs are ignored (0..15).

Ports:
clk  in  1  clock
rst  in  1  reset; asynchronous, active-high
mem_valid_i  in  1  MEM stage holds a real (non-bubble) instruction
stall_i  in  1  MEM stage stalled this cycle
pc_i  in  32  PC of the MEM-stage instruction
is_in_delayslot_i  in  1  instruction is in a branch delay slot
mem_addr_i  in  32  data address of the load/store
exc_adel_if_i  in  1  fetch address error
exc_ri_i  in  1  reserved instruction
exc_sys_i  in  1  syscall
exc_bp_i  in  1  break
exc_ov_i  in  1  arithmetic overflow
exc_adel_ld_i  in  1  load address error
exc_ades_i  in  1  store address error
eret_i  in  1  ERET in MEM
status_i  in  32  forwarded CP0 Status
cause_i  in  32  forwarded CP0 Cause
epc_i  in  32  forwarded CP0 EPC
exception_occured_o  out  1  one-cycle report to CP0
exc_code_o  out  5  ExcCode; 5'h10 denotes ERET
epc_pc_o  out  32  PC reported to CP0
is_in_delayslot_o  out  1  delay-slot flag reported to CP0
bad_addr_o  out  32  BadVAddr candidate
flush_o  out  1  flush all stages up to and including MEM
new_pc_o  out  32  redirect target, valid while flush_o=1

Behaviour:
- Reset: all outputs 0; state IDLE; blank counter 0. Reset mid-flush or mid-blank returns to IDLE immediately.
- int_pending = |(status_i[15:8] & cause_i[15:8]) & status_i[0] & ~status_i[1].
- take = state==IDLE & mem_valid_i & ~stall_i & (int_pending | any exc flag | eret_i).
- Priority, highest first, with the code it selects:
  - interrupt 5'h00
  - adel_if 5'h04
  - ri 5'h0a
  - sys 5'h08
  - bp 5'h09
  - ov 5'h0c
  - adel_ld 5'h04
  - ades 5'h05
  - eret 5'h10
- bad_addr_o: pc_i for adel_if; mem_addr_i for adel_ld or ades; 0 otherwise.
- Latency: outputs are registered. When take is true at edge N, the following hold during cycle N+1 for exactly one cycle:
  - exception_occured_o=1 and flush_o=1
  - exc_code_o, epc_pc_o=pc_i, is_in_delayslot_o and bad_addr_o latched
- new_pc_o = epc_i for ERET, EXC_VECTOR otherwise (see optional feature).
- In all other cycles exception_occured_o=0 and flush_o=0. Data outputs hold their last values.
- FSM:
  - IDLE -> FLUSH on take.
  - FLUSH (1 cycle, pulses asserted) -> BLANK, loading counter with BLANK_CYCLES; goes -> IDLE instead if BLANK_CYCLES==0.
  - BLANK decrements the counter each cycle -> IDLE when the counter reaches 1.
  - All inputs are ignored outside IDLE.
- Stall: while stall_i=1 no event is taken. A pending exception is reported on the first cycle stall_i drops, with inputs still present.
- Interrupt only on a valid instruction; bubbles never carry EPC. Interrupt plus a synchronous exception on the same instruction: interrupt wins (code 0).
- ERET plus another exception flag: the exception wins; ERET is not reported.

Optional Feature:
EXC_BEV_EN. Defined: non-ERET new_pc_o = status_i[22] ? 32'hBFC00380 : 32'h80000180, using status_i sampled at the take edge; EXC_VECTOR is unused. Undefined: always EXC_VECTOR, and status_i[22] is ignored.

Test Plan:
- Syscall, pc_i=32'h8000_1000, valid, no stall -> next cycle: one-cycle exception_occured_o=1, flush_o=1, exc_code_o=5'h08, epc_pc_o=32'h8000_1000, new_pc_o=32'hBFC00380.
- ades, mem_addr_i=32'h0000_0003, is_in_delayslot_i=1 -> exc_code_o=5'h05, bad_addr_o=32'h3, is_in_delayslot_o=1.
- status_i=32'h0000_0401, cause_i=32'h0000_0400, ov also set -> exc_code_o=5'h00 (interrupt wins). Repeat with status_i[1]=1 -> ov reported, 5'h0c.
- eret_i, epc_i=32'hBFC0_0100 -> exc_code_o=5'h10, new_pc_o=32'hBFC0_0100.
- Two back-to-back exceptions, BLANK_CYCLES=2 -> second ignored during FLUSH plus 2 BLANK cycles; taken on the first IDLE cycle it is still present. Stall held 3 cycles on an ri -> report on the cycle after stall_i falls.
- Assert rst during BLANK -> all outputs 0 asynchronously; next syscall is taken normally.
